div_scheduler: RTL

DIV_SCHEDULER -- requirements
Module: div_scheduler

---
 rtl/div_scheduler.sv | 115 +++++++++++
 1 files changed

// File: rtl/div_scheduler.sv
// Programmable tick scheduler: emits a one-cycle tick every cfg_div+1 cycles and a
// square wave div_out that toggles after each tick; stop ends on a div_out falling edge.
module div_scheduler #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic             start,
    input  logic             stop,
    output logic             tick,
    output logic             div_out,
    output logic             running,
    output logic [7:0]       period_cnt,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] div_reg;
    logic [WIDTH-1:0] shadow;
    logic             shadow_pend;
    logic [WIDTH-1:0] cnt;

    logic cnt_zero;
    logic cfg_xfer;
    logic exiting;

    // Handshake: an offer transfers on a rising edge where cfg_valid and cfg_ready are
    // both high; cfg_valid may be held across a stall and is taken once cfg_ready returns.
    assign cfg_ready = (state == IDLE) || !shadow_pend;
    assign cfg_xfer  = cfg_valid && cfg_ready;

    assign running   = (state != IDLE);
    assign cnt_zero  = (cnt == '0);
    assign tick      = running && cnt_zero;
    assign state_dbg = state;

    // The tick that drops div_out while stopping is the last one of the run.
    assign exiting   = (state == STOP) && tick && div_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            div_reg     <= '1;
            shadow      <= '0;
            shadow_pend <= 1'b0;
            div_out     <= 1'b0;
            period_cnt  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_xfer) begin
                        div_reg <= cfg_div;
                    end
                    if (start && !stop) begin
                        state <= RUN;
                        cnt   <= div_reg;
                    end
                end

                RUN, STOP: begin
                    if ((state == RUN) && stop) begin
                        state <= STOP;
                    end

                    if (cnt_zero) begin
                        div_out     <= !div_out;
                        shadow_pend <= 1'b0;
                        if (div_out) begin
                            period_cnt <= period_cnt + 8'd1;
                        end
                        if (shadow_pend) begin
                            cnt     <= shadow;
                            div_reg <= shadow;
                        end else begin
                            cnt     <= div_reg;
                        end
                        if (exiting) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end else begin
                        cnt <= cnt - WIDTH'(1);
                    end

                    // An offer accepted on the final tick goes straight to div_reg,
                    // so IDLE never holds a pending shadow value.
                    if (cfg_xfer) begin
                        if (exiting) begin
                            div_reg <= cfg_div;
                        end else begin
                            shadow      <= cfg_div;
                            shadow_pend <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
